// File: rtl/mem_access_stage.sv
// MEM stage: runs one word load/store per instruction on a valid/ready data bus,
// stalls upstream while the transaction is in flight, and registers the MEM/WB result.
module mem_access_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  input  logic               ex_is_load,
  input  logic               ex_is_store,
  input  logic [XLEN-1:0]    ex_alu_result,
  input  logic [XLEN-1:0]    ex_store_data,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               ex_reg_write,
  output logic               stall_o,
  output logic               mem_req,
  output logic               mem_we,
  output logic [XLEN-1:0]    mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic               mem_ready,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               wb_valid,
  output logic               wb_reg_write,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]    wb_data,
  output logic               misalign_err,
  output logic               bus_err,
  output logic [1:0]         dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Bus handshake: a request is presented while mem_req=1 and is accepted in the
  // cycle mem_ready=1; mem_addr/mem_we/mem_wdata stay stable until then. Read data
  // is taken only in a cycle with mem_rvalid=1 while a load awaits it (RESP, or
  // together with mem_ready in REQ); mem_rvalid at any other time is ignored.

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [XLEN-1:0]    mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]    mem_wdata_q, mem_wdata_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               reg_write_q, reg_write_d;
  logic               wb_valid_q, wb_valid_d;
  logic               wb_reg_write_q, wb_reg_write_d;
  logic [RADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]    wb_data_q, wb_data_d;
  logic               misalign_err_q, misalign_err_d;
  logic               bus_err_q, bus_err_d;

  logic mem_op;
  logic misaligned;
  logic busy;
  logic complete;
  logic timeout;
  logic stall;

  assign mem_op     = ex_valid & (ex_is_load | ex_is_store);
  assign misaligned = (ex_alu_result[1:0] != 2'b00);
  assign busy       = (state_q == ST_REQ) || (state_q == ST_RESP);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    rd_d           = rd_q;
    reg_write_d    = reg_write_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = wb_reg_write_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    misalign_err_d = 1'b0;
    bus_err_d      = 1'b0;
    complete       = 1'b0;
    timeout        = 1'b0;
    stall          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid && !mem_op) begin
          wb_valid_d     = 1'b1;
          wb_data_d      = ex_alu_result;
          wb_rd_d        = ex_rd;
          wb_reg_write_d = ex_reg_write;
        end else if (mem_op && misaligned) begin
          wb_valid_d     = 1'b1;
          wb_rd_d        = ex_rd;
          wb_reg_write_d = 1'b0;
          misalign_err_d = 1'b1;
        end else if (mem_op) begin
          // A load+store encoding is treated as a store.
          stall       = 1'b1;
          state_d     = ST_REQ;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = ex_is_store;
          mem_addr_d  = {ex_alu_result[XLEN-1:2], 2'b00};
          mem_wdata_d = ex_store_data;
          rd_d        = ex_rd;
          reg_write_d = ex_reg_write;
        end
      end
      ST_REQ:  complete = mem_ready && (mem_we_q || mem_rvalid);
      ST_RESP: complete = mem_rvalid;
      default: state_d = ST_IDLE;
    endcase

    if (busy) begin
      // Completion in the final allowed cycle beats the timeout.
      timeout = (cnt_q == CNT_LAST) && !complete;
      stall   = !(complete || timeout);
      cnt_d   = cnt_q + CNT_ONE;
      if (complete) begin
        state_d    = ST_IDLE;
        mem_req_d  = 1'b0;
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        if (mem_we_q) begin
          wb_reg_write_d = 1'b0;
        end else begin
          wb_reg_write_d = reg_write_q;
          wb_data_d      = mem_rdata;
        end
      end else if (timeout) begin
        state_d        = ST_IDLE;
        mem_req_d      = 1'b0;
        wb_valid_d     = 1'b1;
        wb_rd_d        = rd_q;
        wb_reg_write_d = 1'b0;
        bus_err_d      = 1'b1;
      end else if ((state_q == ST_REQ) && mem_ready) begin
        state_d   = ST_RESP;
        mem_req_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rd_q           <= '0;
      reg_write_q    <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      misalign_err_q <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      misalign_err_q <= misalign_err_d;
      bus_err_q      <= bus_err_d;
    end
  end

  assign stall_o      = stall;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign misalign_err = misalign_err_q;
  assign bus_err      = bus_err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, randomized ops against a
// transaction-level model, and a reset-during-response sequence.
module tb_mem_access_stage;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int TIMEOUT = 8;
  localparam int EW      = 32 + 3 + RADDR_W + XLEN;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0;
  logic [XLEN-1:0]    ex_alu_result = '0, ex_store_data = '0;
  logic [RADDR_W-1:0] ex_rd = '0;
  logic               ex_reg_write = 1'b0;
  logic               stall_o, mem_req, mem_we;
  logic [XLEN-1:0]    mem_addr, mem_wdata;
  logic               mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [XLEN-1:0]    mem_rdata = '0;
  logic               wb_valid, wb_reg_write;
  logic [RADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]    wb_data;
  logic               misalign_err, bus_err;
  logic [1:0]         dbg_state;

  mem_access_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .stall_o(stall_o), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [XLEN-1:0] last_data = '0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected entry: {wb cycle, bus_err, misalign_err, wb_reg_write, wb_rd, wb_data}
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wb", {31'b0, wb_valid}, 0);
      end else begin
        e = exp_q.pop_front();
        check("wb_cycle", cyc, e[EW-1:EW-32]);
        check("bus_err", {31'b0, bus_err}, {31'b0, e[39]});
        check("misalign_err", {31'b0, misalign_err}, {31'b0, e[38]});
        check("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, e[37]});
        check("wb_rd", {27'b0, wb_rd}, {27'b0, e[36:32]});
        check("wb_data", wb_data, e[31:0]);
      end
    end else begin
      check("err_without_wb", {30'b0, misalign_err, bus_err}, 0);
      if (exp_q.size() != 0 && int'(exp_q[0][EW-1:EW-32]) < cyc) begin
        check("wb_missing", {31'b0, wb_valid}, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- vectors and model ----------------
  typedef struct {
    logic valid, ld, st;
    logic [XLEN-1:0] addr, wdata;
    logic [RADDR_W-1:0] rd;
    logic rw;
    int rdy, rv;
    logic [XLEN-1:0] rdata;
    int e_lat;
    logic e_mis, e_berr, e_rw, e_hold;
    logic [XLEN-1:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic valid, ld, st, input logic [XLEN-1:0] addr, wdata,
                              input logic [RADDR_W-1:0] rd, input logic rw, input int rdy, rv,
                              input logic [XLEN-1:0] rdata, input int e_lat,
                              input logic e_mis, e_berr, e_rw, e_hold,
                              input logic [XLEN-1:0] e_data);
    vec_t v;
    v.valid = valid; v.ld = ld; v.st = st; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.rw = rw; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.e_lat = e_lat; v.e_mis = e_mis;
    v.e_berr = e_berr; v.e_rw = e_rw; v.e_hold = e_hold; v.e_data = e_data;
    return v;
  endfunction

  // Transaction model: bus cycles needed vs. the timeout budget.
  function automatic vec_t predict(input vec_t v);
    vec_t r = v;
    logic mem, mis, is_ld;
    int need, n;
    mem   = v.valid && (v.ld || v.st);
    is_ld = v.ld && !v.st;
    mis   = mem && (v.addr % 4 != 0);
    need  = (!mem || mis) ? 0 : (is_ld ? v.rdy + 1 + v.rv : v.rdy + 1);
    n     = (need > TIMEOUT) ? TIMEOUT : need;
    r.e_lat  = n + 1;
    r.e_mis  = mis;
    r.e_berr = need > TIMEOUT;
    r.e_rw   = !mem ? v.rw : ((is_ld && !mis && !r.e_berr) ? v.rw : 1'b0);
    r.e_hold = mem && !(is_ld && !mis && !r.e_berr);
    r.e_data = !mem ? v.addr : v.rdata;
    return r;
  endfunction

  // ---------------- driver ----------------
  // Enters just after a negedge; leaves just after the negedge following release.
  task automatic run_op(input vec_t v);
    logic mem, st_eff, ld_eff, mis, released;
    logic [XLEN-1:0] d;
    int n, exp_req, stalls, reqs, hs;
    mem    = v.valid && (v.ld || v.st);
    st_eff = v.st;
    ld_eff = v.ld && !v.st;
    mis    = mem && (v.addr % 4 != 0);
    ex_valid = v.valid; ex_is_load = v.ld; ex_is_store = v.st; ex_alu_result = v.addr;
    ex_store_data = v.wdata; ex_rd = v.rd; ex_reg_write = v.rw;
    if (v.valid) begin
      d = v.e_hold ? last_data : v.e_data;
      last_data = d;
      exp_q.push_back({32'(cyc + v.e_lat), v.e_berr, v.e_mis, v.e_rw, v.rd, d});
    end
    n       = v.valid ? v.e_lat - 1 : 0;
    exp_req = (mem && !mis) ? ((v.rdy + 1 < n) ? v.rdy + 1 : n) : 0;
    stalls = 0; reqs = 0; hs = -1; released = 1'b0;
    for (int i = 0; i < 4 * TIMEOUT + 8 && !released; i++) begin
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (mem_req) begin
        check("mem_we", {31'b0, mem_we}, {31'b0, st_eff});
        check("mem_addr", mem_addr, v.addr);
        if (st_eff) check("mem_wdata", mem_wdata, v.wdata);
        if (reqs == v.rdy) begin mem_ready = 1'b1; hs = i; end
        reqs++;
      end
      if (ld_eff && hs >= 0 && i == hs + v.rv) begin
        mem_rvalid = 1'b1; mem_rdata = v.rdata;
      end else if (mem_req && !mem_ready && $urandom_range(3) == 0) begin
        mem_rvalid = 1'b1;
      end
      #1;
      if (stall_o) stalls++; else released = 1'b1;
      @(negedge clk);
    end
    check("release_seen", {31'b0, released}, 1);
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    check("stall_cycles", stalls, n);
    check("req_cycles", reqs, exp_req);
    check("req_dropped", {31'b0, mem_req}, 0);
  endtask

  task automatic drain();
    repeat (TIMEOUT + 4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, {31'b0, mem_req}, 0);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_wb_valid"}, {31'b0, wb_valid}, 0);
    check({tag, "_wb_reg_write"}, {31'b0, wb_reg_write}, 0);
    check({tag, "_wb_rd"}, {27'b0, wb_rd}, 0);
    check({tag, "_wb_data"}, wb_data, 0);
    check({tag, "_errs"}, {30'b0, misalign_err, bus_err}, 0);
  endtask

  // ---------------- test ----------------
  vec_t vecs[14];

  initial begin
    vec_t rv;
    int kind;

    vecs[0]  = mk(1, 0, 0, 32'h1234, 0, 5, 1, 0, 0, 0, 1, 0, 0, 1, 0, 32'h1234);
    vecs[1]  = mk(1, 0, 1, 32'h100, 32'hDEADBEEF, 6, 1, 2, 0, 0, 4, 0, 0, 0, 1, 0);
    vecs[2]  = mk(1, 1, 0, 32'h40, 0, 7, 1, 0, 2, 32'hCAFEF00D, 4, 0, 0, 1, 0, 32'hCAFEF00D);
    vecs[3]  = mk(1, 1, 0, 32'h102, 0, 8, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    vecs[4]  = mk(1, 1, 0, 32'h80, 0, 3, 1, 0, 0, 32'h11112222, 2, 0, 0, 1, 0, 32'h11112222);
    vecs[5]  = mk(1, 0, 1, 32'h104, 32'h0BAD0BAD, 2, 0, 1000, 0, 0, 9, 0, 1, 0, 1, 0);
    vecs[6]  = mk(1, 1, 0, 32'h44, 0, 9, 1, 1, 1, 32'h5A5A0001, 4, 0, 0, 1, 0, 32'h5A5A0001);
    vecs[7]  = mk(1, 0, 1, 32'h108, 32'h12345678, 0, 0, 7, 0, 0, 9, 0, 0, 0, 1, 0);
    vecs[8]  = mk(1, 1, 0, 32'h48, 0, 10, 1, 3, 4, 32'h77, 9, 0, 0, 1, 0, 32'h77);
    vecs[9]  = mk(1, 1, 0, 32'h4C, 0, 11, 1, 3, 5, 32'hFFFF0000, 9, 0, 1, 0, 1, 0);
    vecs[10] = mk(1, 1, 1, 32'h200, 32'hA5A5A5A5, 12, 1, 0, 0, 0, 2, 0, 0, 0, 1, 0);
    vecs[11] = mk(1, 0, 1, 32'h203, 32'h1, 13, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    vecs[12] = mk(1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hFFFFFFFF);
    vecs[13] = mk(0, 1, 0, 32'h40, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_stall", {31'b0, stall_o}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_op(vecs[i]);
    drain();

    for (int i = 0; i < 150; i++) begin
      rv = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rv.valid = ($urandom_range(9) != 0);
      kind     = $urandom_range(3);
      rv.ld    = (kind == 1) || (kind == 3);
      rv.st    = (kind == 2) || (kind == 3);
      rv.addr  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(4) == 0) rv.addr = rv.addr | $urandom_range(1, 3);
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.rd    = RADDR_W'($urandom_range(31));
      rv.rw    = $urandom_range(1) == 1;
      rv.rdy   = ($urandom_range(9) == 0) ? 1000 : $urandom_range(0, 5);
      rv.rv    = $urandom_range(0, 4);
      run_op(predict(rv));
    end
    drain();

    // Reset while a load is waiting for read data.
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0;
    ex_alu_result = 32'h300; ex_rd = 4; ex_reg_write = 1'b1;
    @(negedge clk);
    check("rst_seq_req", {31'b0, mem_req}, 1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("rst_seq_resp_req", {31'b0, mem_req}, 0);
    #1 check("rst_seq_resp_stall", {31'b0, stall_o}, 1);
    ex_valid = 1'b0; ex_is_load = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_resp");
    rst_n = 1'b1;
    last_data = '0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
    #1 check("late_rvalid_stall", {31'b0, stall_o}, 0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rvalid_wb", {31'b0, wb_valid}, 0);
    check("late_rvalid_data", wb_data, 0);
    run_op(vecs[2]);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
